// File: rtl/mac_requant.sv
// mac_requant: bias add, round-half-up arithmetic shift and saturation of MAC accumulators,
// buffered through a 2-entry valid/ready FIFO with a sticky saturation counter.
module mac_requant #(
    parameter int LEN_ACC   = 18,
    parameter int LEN_OUT   = 8,
    parameter int LEN_SHIFT = 4
) (
    input  logic                        CLK,
    input  logic                        SYNC_RST,
    input  logic                        ACC_VALID,
    output logic                        ACC_READY,
    input  logic signed [LEN_ACC-1:0]   ACC_IN,
    input  logic signed [LEN_ACC-1:0]   BIAS,
    input  logic        [LEN_SHIFT-1:0] SHIFT,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic signed [LEN_OUT-1:0]   DATA_OUT,
    output logic                        SAT_FLAG,
    output logic        [15:0]          SAT_COUNT
);
    localparam logic signed [LEN_ACC+1:0] MAX_V = {{(LEN_ACC+3-LEN_OUT){1'b0}}, {(LEN_OUT-1){1'b1}}};
    localparam logic signed [LEN_ACC+1:0] MIN_V = {{(LEN_ACC+3-LEN_OUT){1'b1}}, {(LEN_OUT-1){1'b0}}};
    localparam logic signed [LEN_ACC+1:0] ONE   = {{(LEN_ACC+1){1'b0}}, 1'b1};

    logic                        s1_valid_q, s1_valid_d;
    logic signed [LEN_ACC:0]     s1_sum_q, s1_sum_d;
    logic [LEN_SHIFT-1:0]        s1_shift_q, s1_shift_d;
    logic [LEN_OUT-1:0]          mem_data_q [2];
    logic [LEN_OUT-1:0]          mem_data_d [2];
    logic [1:0]                  mem_sat_q, mem_sat_d;
    logic                        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [15:0]                 sat_cnt_q, sat_cnt_d;
    logic                        accept, push, pop, sat_hi, sat_lo, w_sat;
    logic signed [LEN_ACC+1:0]   rnd, r, q;
    logic [LEN_OUT-1:0]          w_data;

    always_comb begin
        pop       = (cnt_q != 2'd0) && OUT_READY;
        push      = s1_valid_q && (cnt_q != 2'd2 || pop);
        // readiness looks only at registered state so OUT_READY never reaches ACC_READY
        ACC_READY = !SYNC_RST && (!s1_valid_q || cnt_q != 2'd2);
        accept    = ACC_VALID && ACC_READY;
        rnd       = (s1_shift_q == '0) ? '0 : ONE << (s1_shift_q - {{(LEN_SHIFT-1){1'b0}}, 1'b1});
        r         = {s1_sum_q[LEN_ACC], s1_sum_q} + rnd;
        q         = r >>> s1_shift_q;
        sat_hi    = q > MAX_V;
        sat_lo    = q < MIN_V;
        w_sat     = sat_hi || sat_lo;
        w_data    = sat_hi ? MAX_V[LEN_OUT-1:0] : sat_lo ? MIN_V[LEN_OUT-1:0] : q[LEN_OUT-1:0];
        s1_valid_d = accept || (s1_valid_q && !push);
        s1_sum_d   = accept ? {ACC_IN[LEN_ACC-1], ACC_IN} + {BIAS[LEN_ACC-1], BIAS} : s1_sum_q;
        s1_shift_d = accept ? SHIFT : s1_shift_q;
        mem_data_d = mem_data_q;
        mem_sat_d  = mem_sat_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = w_data;
            mem_sat_d[wr_ptr_q]  = w_sat;
        end
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ pop;
        cnt_d     = (push && !pop) ? cnt_q + 2'd1 : (pop && !push) ? cnt_q - 2'd1 : cnt_q;
        sat_cnt_d = (push && w_sat && sat_cnt_q != 16'hFFFF) ? sat_cnt_q + 16'd1 : sat_cnt_q;
        OUT_VALID = cnt_q != 2'd0;
        DATA_OUT  = OUT_VALID ? mem_data_q[rd_ptr_q] : '0;
        SAT_FLAG  = OUT_VALID && mem_sat_q[rd_ptr_q];
        SAT_COUNT = sat_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
            mem_data_q <= '{default: '0};
            mem_sat_q  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_shift_q <= s1_shift_d;
            mem_data_q <= mem_data_d;
            mem_sat_q  <= mem_sat_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end
endmodule
